// File: rtl/lsu.sv
// RV32I load/store unit: one aligned data-memory access per request, with
// lane steering for stores, extension for loads and fault/timeout reporting.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for req; request fields are latched on acceptance
// ACCESS | strobe held until mem_ready or timeout; strobe low = fault pending
// RESP   | done (and fault) asserted for one cycle, then back to IDLE
module lsu #(
   parameter int WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  fn3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] WAIT_LD = 8'(WAIT_MAX);

   state_t      state;
   logic        we_q;
   logic [2:0]  fn3_q;
   logic [1:0]  off_q;
   logic [7:0]  cnt;

   logic        legal;
   logic        misal;
   logic        ok;
   logic [3:0]  wmask_n;
   logic [31:0] wdata_n;
   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic        strobe;

   always_comb begin
      legal   = 1'b0;
      misal   = 1'b0;
      wmask_n = 4'b0000;
      wdata_n = wdata;
      if (we)
         legal = (fn3 == 3'b000) || (fn3 == 3'b001) || (fn3 == 3'b010);
      else
         legal = (fn3 == 3'b000) || (fn3 == 3'b001) || (fn3 == 3'b010) ||
                 (fn3 == 3'b100) || (fn3 == 3'b101);
      case (fn3[1:0])
         2'b00: begin
            wmask_n = 4'b0001 << addr[1:0];
            wdata_n = {4{wdata[7:0]}};
         end
         2'b01: begin
            misal   = addr[0];
            wmask_n = 4'b0011 << addr[1:0];
            wdata_n = {2{wdata[15:0]}};
         end
         default: begin
            misal   = (addr[1:0] != 2'b00);
            wmask_n = 4'b1111;
            wdata_n = wdata;
         end
      endcase
      ok = legal && !misal;
   end

   // Extension is applied straight to the bus word so rdata lands with done.
   always_comb begin
      shifted  = mem_rdata >> {off_q, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (fn3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'h000000, byte_sel};
         3'b101:  load_ext = {16'h0000, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   assign strobe = mem_rd || mem_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         rdata     <= 32'h0;
         mem_addr  <= 32'h0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wmask <= 4'b0000;
         mem_wdata <= 32'h0;
         we_q      <= 1'b0;
         fn3_q     <= 3'b000;
         off_q     <= 2'b00;
         cnt       <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state     <= ACCESS;
                  busy      <= 1'b1;
                  we_q      <= we;
                  fn3_q     <= fn3;
                  off_q     <= addr[1:0];
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_wdata <= wdata_n;
                  mem_wmask <= (we && ok) ? wmask_n : 4'b0000;
                  mem_rd    <= !we && ok;
                  mem_wr    <= we && ok;
                  cnt       <= WAIT_LD;
               end
            end
            ACCESS: begin
               if (strobe && mem_ready) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  rdata  <= we_q ? 32'h0 : load_ext;
                  fault  <= 1'b0;
                  done   <= 1'b1;
                  state  <= RESP;
               end else if (strobe) begin
                  // terminal count: drop strobes, the next cycle reports the fault
                  if (cnt == 8'd1) begin
                     mem_rd <= 1'b0;
                     mem_wr <= 1'b0;
                  end
                  cnt <= cnt - 8'd1;
               end else begin
                  rdata <= 32'h0;
                  fault <= 1'b1;
                  done  <= 1'b1;
                  state <= RESP;
               end
            end
            RESP: begin
               done      <= 1'b0;
               fault     <= 1'b0;
               busy      <= 1'b0;
               mem_wmask <= 4'b0000;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
